// File: rtl/imem_pkg.sv
// Shared instruction-memory constants and loader state encoding.
// Reused by the memory write port and the core fetch stage.
package imem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W:0]   count_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        DONE = 2'b10
    } loadState_t;

    // A single load never needs more than one pass over the memory.
    function automatic count_t clampLen(input count_t len);
        return (len > count_t'(DEPTH)) ? count_t'(DEPTH) : len;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Boot-path word stream into the loader, and the loader's memory write port.

interface imem_stream_if;
    import imem_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t in_data;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

interface imem_wr_if;
    import imem_pkg::*;

    logic  mem_we;
    addr_t mem_addr;
    word_t mem_wdata;

    modport master (output mem_we, output mem_addr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/imem_loader.sv
// Streams a burst of instruction words into the instruction memory at
// sequential wrapping addresses, holding the core until the load finishes.
module imem_loader
    import imem_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_start,
    input  addr_t         load_base,
    input  count_t        load_len,
    imem_stream_if.slave  stream,
    imem_wr_if.master     wr,
    output logic          cpu_hold,
    output logic          load_busy,
    output logic          load_done,
    output count_t        words_loaded
);

    loadState_t state, stateNext;
    addr_t      wrPtr;
    count_t     remaining;
    logic       startOk;
    logic       xfer;

    assign startOk         = load_start && (load_len != '0);
    assign stream.in_ready = (state == LOAD);
    assign xfer            = stream.in_valid && (state == LOAD);
    assign load_busy       = (state != IDLE);
    assign load_done       = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (startOk) stateNext = LOAD;
            LOAD:    if (xfer && remaining == count_t'(1)) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Write port lags acceptance by one cycle, so the DONE cycle carries
    // the final word together with the load_done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr        <= '0;
            remaining    <= '0;
            words_loaded <= '0;
            cpu_hold     <= 1'b1;
            wr.mem_we    <= 1'b0;
            wr.mem_addr  <= '0;
            wr.mem_wdata <= '0;
        end else begin
            wr.mem_we <= xfer;
            if (state == IDLE && startOk) begin
                wrPtr        <= load_base;
                remaining    <= clampLen(load_len);
                words_loaded <= '0;
                cpu_hold     <= 1'b1;
            end
            if (xfer) begin
                wr.mem_addr  <= wrPtr;
                wr.mem_wdata <= stream.in_data;
                wrPtr        <= wrPtr + 1'b1;
                remaining    <= remaining - 1'b1;
                words_loaded <= words_loaded + 1'b1;
            end
            // Release the core only once the last word has hit the memory.
            if (state == DONE) cpu_hold <= 1'b0;
        end
    end

    doneWrites: assert property (@(posedge clk) disable iff (!rst_n)
        (state == DONE) |-> wr.mem_we);

    legalState: assert property (@(posedge clk) disable iff (!rst_n)
        state inside {IDLE, LOAD, DONE});

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader against a behavioural loader model.
module tb_imem_loader;
    import imem_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   load_start = 1'b0;
    addr_t  load_base = '0;
    count_t load_len = '0;
    logic   cpu_hold, load_busy, load_done;
    count_t words_loaded;

    imem_stream_if s();
    imem_wr_if     w();

    imem_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start   (load_start),
        .load_base    (load_base),
        .load_len     (load_len),
        .stream       (s),
        .wr           (w),
        .cpu_hold     (cpu_hold),
        .load_busy    (load_busy),
        .load_done    (load_done),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; logic [31:0] data; } wrExp_t;
    wrExp_t sbQ[$];

    int nCmp = 0;
    int nErr = 0;
    int doneCnt = 0;
    int hits[DEPTH];

    // Reference model: words left, next address, hold/done flags.
    int          mRem = 0, mPtr = 0, mWords = 0, mLastAddr = 0;
    bit          mHold = 1'b1, mDone = 1'b0, mWe = 1'b0;
    logic [31:0] mLastData = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mRem = 0; mPtr = 0; mWords = 0; mHold = 1'b1; mDone = 1'b0; mWe = 1'b0;
            mLastAddr = 0; mLastData = '0;
            sbQ.delete();
        end else begin
            mWe = 1'b0;
            if (mDone) begin
                mDone = 1'b0;
                mHold = 1'b0;
            end else if (mRem > 0) begin
                if (s.in_valid) begin
                    sbQ.push_back('{mPtr, s.in_data});
                    mLastAddr = mPtr;
                    mLastData = s.in_data;
                    mPtr = (mPtr + 1) % DEPTH;
                    mRem--;
                    mWords++;
                    mWe = 1'b1;
                    if (mRem == 0) mDone = 1'b1;
                end
            end else if (load_start && load_len != 0) begin
                mRem   = (int'(load_len) > DEPTH) ? DEPTH : int'(load_len);
                mPtr   = int'(load_base);
                mWords = 0;
                mHold  = 1'b1;
            end
        end
    end

    // Monitor: status outputs every cycle, write port against the scoreboard.
    always @(negedge clk) begin
        wrExp_t e;
        chk("in_ready",     s.in_ready,   mRem > 0);
        chk("load_busy",    load_busy,    (mRem > 0) || mDone);
        chk("load_done",    load_done,    mDone);
        chk("cpu_hold",     cpu_hold,     mHold);
        chk("words_loaded", words_loaded, mWords);
        chk("mem_we",       w.mem_we,     mWe);
        if (load_done) doneCnt++;
        if (w.mem_we === 1'b1) begin
            if (sbQ.size() == 0) begin
                nCmp++; nErr++;
                $display("FAIL sb_write: got write to %0h expected no write", w.mem_addr);
            end else begin
                e = sbQ.pop_front();
                chk("mem_addr",  w.mem_addr,  e.addr);
                chk("mem_wdata", w.mem_wdata, e.data);
                hits[int'(w.mem_addr)]++;
            end
        end else begin
            chk("hold_addr",  w.mem_addr,  mLastAddr);
            chk("hold_wdata", w.mem_wdata, mLastData);
        end
    end

    task automatic startLoad(input int base, input int len);
        @(negedge clk);
        load_start = 1'b1;
        load_base  = addr_t'(base);
        load_len   = count_t'(len);
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // gap < 0 picks a random 0..2 idle cycles after each accepted word.
    task automatic sendWords(input int n, input int gap, input logic [31:0] dBase, output int acc);
        int stall = 0;
        int g;
        logic [31:0] cur;
        bit fresh = 1'b1;
        acc = 0;
        while (acc < n && stall < 8) begin
            @(negedge clk);
            if (fresh) cur = (dBase != 0) ? dBase + acc : $urandom;
            s.in_valid = 1'b1;
            s.in_data  = cur;
            if (s.in_ready) begin
                acc++;
                stall = 0;
                fresh = 1'b1;
                g = (gap < 0) ? $urandom_range(2, 0) : gap;
                repeat (g) begin
                    @(negedge clk);
                    s.in_valid = 1'b0;
                end
            end else begin
                stall++;
                fresh = 1'b0;
            end
        end
        @(negedge clk);
        s.in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int t = 0;
        while (load_busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (load_busy) begin
            nCmp++; nErr++;
            $display("FAIL idle_timeout: got busy expected idle within 20 cycles");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, bad, d0, len;
        s.in_valid = 1'b0;
        s.in_data  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Zero-length request is ignored.
        startLoad(8'h33, 0);
        repeat (3) @(negedge clk);

        startLoad(8'h10, 4);
        sendWords(4, 0, 32'hA0000001, acc);
        chk("acc_len4", acc, 4);
        waitIdle();

        // Wrap across the top of memory with idle gaps.
        startLoad(8'hFE, 4);
        sendWords(4, 2, 32'h0, acc);
        waitIdle();

        // Oversize length clamps to a single full pass.
        foreach (hits[i]) hits[i] = 0;
        startLoad(8'h00, 300);
        sendWords(300, 0, 32'h0, acc);
        chk("acc_clamp", acc, 256);
        bad = 0;
        foreach (hits[i]) if (hits[i] != 1) bad++;
        chk("full_cover", bad, 0);
        waitIdle();

        // Mid-load restart request is ignored.
        startLoad(8'h40, 6);
        sendWords(3, 0, 32'h0, acc);
        @(negedge clk);
        load_start = 1'b1; load_base = 8'h80; load_len = 9'd5;
        @(negedge clk);
        load_start = 1'b0;
        sendWords(3, 1, 32'h0, acc);
        chk("acc_after_restart", acc, 3);
        waitIdle();

        // Reset during a load, then a fresh short load.
        startLoad(8'h20, 8);
        sendWords(3, 0, 32'h0, acc);
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cpu_hold", cpu_hold, 1'b1);
        @(posedge clk); #1 rst_n = 1'b1;
        d0 = doneCnt;
        startLoad(8'h50, 2);
        sendWords(2, 0, 32'h0, acc);
        waitIdle();
        chk("rst_then_done", doneCnt - d0, 1);

        // Random chained loads, each start issued in the IDLE cycle after DONE.
        repeat (15) begin
            len = ($urandom_range(5, 0) == 0) ? 0 : $urandom_range(12, 1);
            startLoad($urandom_range(255, 0), len);
            if (len > 0) sendWords(len, -1, 32'h0, acc);
        end
        waitIdle();
        repeat (3) @(negedge clk);
        chk("sb_drained", sbQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the 32-bit x 256-deep asynchronous-read instruction memory.
- Accepts a burst of instruction words over a valid/ready stream from the host/NoC boot path and drives the memory's synchronous write port at sequential, wrapping addresses.
- Holds the attached Cardinal core in hold (cpu_hold) from reset until a load completes, and during every reload.

Parameters:
- ADDR_W, 8, instruction memory address width.
- DATA_W, 32, instruction word width.
- DEPTH, 256, memory depth in words; equals 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_start  input  1  single-cycle load request; sampled only in IDLE.
- load_base  input  ADDR_W  first write address, captured with load_start.
- load_len  input  ADDR_W+1  number of words, captured with load_start; 0 ignored; values >DEPTH clamp to DEPTH.
- in_valid  input  1  instruction word present on in_data.
- in_data  input  DATA_W  instruction word.
- in_ready  output  1  loader accepts a word this cycle; transfer when in_valid && in_ready.
- mem_we  output  1  write enable to the instruction memory.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  DATA_W  write data.
- cpu_hold  output  1  keeps the core from fetching while high.
- load_busy  output  1  high in LOAD and DONE.
- load_done  output  1  one-cycle pulse when the final word is written.
- words_loaded  output  ADDR_W+1  words written in the current/last load.

Behaviour:
- Reset values (asynchronous, held while rst_n=0):
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=1, load_busy=0, load_done=0, words_loaded=0.
  - State=IDLE.
- States: IDLE, LOAD, DONE.
- IDLE -> LOAD on load_start=1 with load_len!=0:
  - Capture wr_ptr=load_base and remaining=min(load_len,DEPTH).
  - Clear words_loaded; set cpu_hold=1 and load_busy=1.
- IDLE with load_start=1 and load_len=0: no state change, no pulse, cpu_hold unchanged.
- LOAD: in_ready=1 combinationally from state.
  - On each transfer, the next cycle drives mem_we=1, mem_addr=wr_ptr, mem_wdata=in_data. Write latency is 1 cycle after acceptance.
  - wr_ptr increments modulo DEPTH (255 -> 0, no error). remaining decrements. words_loaded increments.
  - Cycles without in_valid: mem_we=0; address and data hold their last values.
  - The transfer with remaining==1 moves the state to DONE. in_ready is 0 in DONE, so no word beyond load_len is ever accepted.
- DONE, exactly one cycle:
  - mem_we=1 for the last word, load_done=1.
  - Next cycle: IDLE, cpu_hold=0, load_busy=0, mem_we=0.
- load_start during LOAD or DONE is ignored. No queueing, no restart.
- A new load_start in the IDLE cycle immediately after DONE is legal. cpu_hold stays 0 for that one IDLE cycle, then re-asserts.
- A load of DEPTH words starting at any base writes every address exactly once.
- Reset mid-load:
  - Returns to the reset values immediately.
  - Words already written stay in memory and are not cleared.
  - The core stays held until a full load completes.
- words_loaded holds its final value in IDLE until the next accepted load_start.

Decomposition:
- Shared package imem_pkg: ADDR_W, DATA_W, DEPTH constants, and the loader state encoding (IDLE=2'b00, LOAD=2'b01, DONE=2'b10). The package is reusable by the memory and the core fetch stage.
- No sub-module. The pointer and down-counter stay inline.
- The memory write port is a separate block and is not instantiated here.

Test Plan:
- Reset, no load -> cpu_hold=1, in_ready=0, mem_we=0 for 20 cycles. load_len=0 start -> no change.
- load_base=0x10, len=4, words 0xA0000001..0xA0000004 back-to-back:
  - Writes to 0x10..0x13 on consecutive cycles.
  - load_done pulses in the cycle of the 0x13 write.
  - cpu_hold=0 the next cycle. words_loaded=4.
- Base 0xFE, len=4 with in_valid gaps of 2 cycles -> writes to 0xFE, 0xFF, 0x00, 0x01 in order. mem_we is low during the gaps.
- len=300, base 0x00 -> exactly 256 writes covering 0x00..0xFF. in_ready=0 after the 256th acceptance; the 257th word is never taken.
- load_start pulsed mid-LOAD with a different base -> ignored. Original addresses continue.
- rst_n low after 3 of 8 words -> all outputs at reset values, cpu_hold=1. A new len=2 load then completes normally with load_done=1.
